cla_seq_adder: RTL and testbench

- Multi-cycle wide adder/subtractor built around one 4-bit carry-lookahead slice.
- Sequences that slice over a WIDTH-bit operand pair, one nibble per clock, LSB nibble first.
- The slice carry-out is registered and fed back as the next nibble's carry-in.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

---
 rtl/cla_seq_adder.sv | 82 ++++++++
 tb/tb_cla_seq_adder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cla_seq_adder.sv
// cla_seq_adder: multi-cycle WIDTH-bit add/sub reusing one 4-bit carry-lookahead slice, LSB nibble first.
module cla_seq_adder #(
  parameter int WIDTH = 16,
  localparam int NSLICE = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);
  localparam int IW = NSLICE > 1 ? $clog2(NSLICE) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0] idx;
  logic carry;
  logic [3:0] na, nb, g, p, s;
  logic [4:0] c;
  logic last;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign last      = idx == IW'(NSLICE - 1);
  always_comb begin
    na = a_reg[4*idx +: 4];
    nb = b_reg[4*idx +: 4];
    g = na & nb;
    p = na ^ nb;
    c[0] = carry;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s = p ^ c[3:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_reg   <= in_a;
          b_reg   <= in_sub ? ~in_b : in_b;
          carry   <= in_sub ? 1'b1 : in_cin;
          out_sum <= '0;
          idx     <= '0;
          state   <= RUN;
        end
        RUN: begin
          out_sum[4*idx +: 4] <= s;
          carry <= c[4];
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            out_cout <= c[4];
            out_ovf  <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) & (s[3] != a_reg[WIDTH-1]);
            state    <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_seq_adder.sv
// tb_cla_seq_adder: directed-vector self-checking bench for cla_seq_adder (WIDTH=16).
module tb_cla_seq_adder;
  logic clk = 0, rst_n = 0, in_valid = 0, in_cin = 0, in_sub = 0, out_ready = 0;
  logic [15:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, out_cout, out_ovf, busy;
  logic [15:0] out_sum;
  int checks = 0, errors = 0;

  cla_seq_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  // Called #1 after an edge with the DUT idle; scrambles the inputs after the accept edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in_a = 16'hDEAD; in_b = 16'hBEEF; in_cin = ~cin; in_sub = ~sub;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic consume;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b expected 0", out_valid); end
    checks++; if (out_sum !== 16'h0) begin errors++; $display("FAIL reset out_sum: got %h expected 0000", out_sum); end
    checks++; if ({out_cout, out_ovf} !== 2'b00) begin errors++; $display("FAIL reset cout/ovf: got %b%b expected 00", out_cout, out_ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
  endtask

  task automatic test_arith;
    logic [15:0] va[7] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h0005, 16'h8000, 16'h0010};
    logic [15:0] vb[7] = '{16'h0FED, 16'h0001, 16'h0001, 16'h0000, 16'h0007, 16'h0001, 16'h0001};
    logic vc[7] = '{0, 0, 0, 1, 0, 0, 1};
    logic vs[7] = '{0, 0, 0, 0, 1, 1, 1};
    logic [15:0] es[7] = '{16'h2221, 16'h0000, 16'h8000, 16'h0001, 16'hFFFE, 16'h7FFF, 16'h000F};
    logic ec[7] = '{0, 1, 0, 0, 0, 1, 1};
    logic eo[7] = '{0, 0, 1, 0, 0, 1, 0};
    int lat;
    for (int i = 0; i < 7; i++) begin
      start_op(va[i], vb[i], vc[i], vs[i]);
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL arith[%0d] busy/in_ready after accept: got %b/%b expected 1/0", i, busy, in_ready); end
      wait_done(lat);
      checks++; if (lat != 4) begin errors++; $display("FAIL arith[%0d] latency: got %0d expected 4", i, lat); end
      checks++; if (out_sum !== es[i]) begin errors++; $display("FAIL arith[%0d] sum: got %h expected %h", i, out_sum, es[i]); end
      checks++; if (out_cout !== ec[i]) begin errors++; $display("FAIL arith[%0d] cout: got %b expected %b", i, out_cout, ec[i]); end
      checks++; if (out_ovf !== eo[i]) begin errors++; $display("FAIL arith[%0d] ovf: got %b expected %b", i, out_ovf, eo[i]); end
      consume;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL arith[%0d] handshake: valid/ready got %b/%b expected 0/1", i, out_valid, in_ready); end
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    start_op(16'h1111, 16'h2222, 0, 0);
    in_a = 16'h0100; in_b = 16'h0200; in_cin = 0; in_sub = 0; in_valid = 1;
    wait_done(lat);
    checks++; if (lat != 4 || out_sum !== 16'h3333) begin errors++; $display("FAIL bp first op: lat %0d sum %h expected 4 3333", lat, out_sum); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || out_sum !== 16'h3333 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp hold[%0d]: valid %b sum %h in_ready %b expected 1 3333 0", i, out_valid, out_sum, in_ready);
      end
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_sum !== 16'h3333) begin
      errors++; $display("FAIL bp release: in_ready %b valid %b sum %h expected 1 0 3333", in_ready, out_valid, out_sum);
    end
    @(posedge clk); #1;
    in_valid = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp second accept: busy got %b expected 1", busy); end
    wait_done(lat);
    checks++; if (lat != 4 || out_sum !== 16'h0300) begin errors++; $display("FAIL bp second op: lat %0d sum %h expected 4 0300", lat, out_sum); end
    consume;
  endtask

  task automatic test_reset_mid_run;
    int lat;
    bit seen = 0;
    start_op(16'h1234, 16'h1111, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrun ctrl: in_ready %b valid %b busy %b expected 1 0 0", in_ready, out_valid, busy);
    end
    checks++; if (out_sum !== 16'h0 || out_cout !== 1'b0 || out_ovf !== 1'b0) begin
      errors++; $display("FAIL midrun data: sum %h cout %b ovf %b expected 0000 0 0", out_sum, out_cout, out_ovf);
    end
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL midrun spurious valid: got 1 expected 0"); end
    start_op(16'h00FF, 16'h0001, 0, 0);
    wait_done(lat);
    checks++; if (lat != 4 || out_sum !== 16'h0100 || out_cout !== 1'b0) begin
      errors++; $display("FAIL midrun recovery: lat %0d sum %h cout %b expected 4 0100 0", lat, out_sum, out_cout);
    end
    consume;
  endtask

  initial begin
    #12;
    test_reset;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    test_reset;
    test_arith;
    test_back_to_back;
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
